// File: rtl/dmem_access_ctrl_if.sv
// Data-memory request/response bus between the MEM-stage access controller
// and the data memory (or its arbiter).
//
//   dmem_req    controller -> memory  request valid, held until dmem_gnt
//   dmem_we     controller -> memory  1 = store, 0 = load
//   dmem_addr   controller -> memory  word-aligned byte address
//   dmem_wdata  controller -> memory  store data, already replicated onto lanes
//   dmem_be     controller -> memory  byte-lane enables
//   dmem_gnt    memory -> controller  request accepted this cycle
//   dmem_rvalid memory -> controller  load data valid this cycle
//   dmem_rdata  memory -> controller  raw 32-bit load word
interface dmem_access_ctrl_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller.
// Turns a load/store sitting in the MEM stage into a request on the
// data-memory bus, stalls the pipeline until the access completes, formats
// load data and flags misaligned accesses and bus timeouts.
//
// Ports:
//   clk, reset   pipeline clock, asynchronous active-high reset
//   MemWriteM    store in MEM stage
//   ResultSrcM   2'b01 = load in MEM stage
//   Funct3M      access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   ALUResultM   effective byte address
//   WriteDataM   store data
//   bus          data-memory bus (master side)
//   StallMem     freeze the front of the pipeline while an access is pending
//   ReadDataM    formatted load data, valid in the DONE cycle
//   MisalignM    one-cycle pulse for a misaligned access (no bus request made)
//   BusErr       sticky flag: a request or response timed out
module dmem_access_ctrl (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      MemWriteM,
    input  logic [1:0]                ResultSrcM,
    input  logic [2:0]                Funct3M,
    input  logic [31:0]               ALUResultM,
    input  logic [31:0]               WriteDataM,
    dmem_access_ctrl_if.master        bus,
    output logic                      StallMem,
    output logic [31:0]               ReadDataM,
    output logic                      MisalignM,
    output logic                      BusErr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state_reg, state_next;

    logic        req_reg;
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  be_reg;
    logic [2:0]  funct3_reg;
    logic [1:0]  offset_reg;
    logic [7:0]  wait_cnt_reg;
    logic [31:0] read_data_reg;
    logic        bus_err_reg;

    // Decode of the op currently in MEM. A store wins over a load if both
    // are flagged.
    logic        is_load;
    logic        op_present;
    logic        size_half;
    logic        size_word;
    logic        misaligned;

    assign is_load    = (ResultSrcM == 2'b01);
    assign op_present = MemWriteM | is_load;
    assign size_half  = (Funct3M[1:0] == 2'b01);
    assign size_word  = Funct3M[1];
    assign misaligned = (size_half & ALUResultM[0]) |
                        (size_word & (ALUResultM[1:0] != 2'b00));

    // Store lane placement, computed from the live MEM-stage inputs and
    // captured when the access starts.
    logic [3:0]  be_fmt;
    logic [31:0] wdata_fmt;

    always_comb begin
        be_fmt    = 4'b1111;
        wdata_fmt = WriteDataM;
        if (Funct3M[1:0] == 2'b00) begin
            be_fmt    = 4'b0001 << ALUResultM[1:0];
            wdata_fmt = {4{WriteDataM[7:0]}};
        end else if (Funct3M[1:0] == 2'b01) begin
            be_fmt    = ALUResultM[1] ? 4'b1100 : 4'b0011;
            wdata_fmt = {2{WriteDataM[15:0]}};
        end
    end

    // Load formatting uses the size/offset captured at start, since the
    // MEM-stage inputs are only guaranteed stable while stalled.
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_fmt;

    always_comb begin
        load_byte = bus.dmem_rdata[{offset_reg, 3'b000} +: 8];
        load_half = offset_reg[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        case (funct3_reg)
            3'b000:  load_fmt = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_fmt = {{16{load_half[15]}}, load_half};
            3'b100:  load_fmt = {24'h000000, load_byte};
            3'b101:  load_fmt = {16'h0000, load_half};
            default: load_fmt = bus.dmem_rdata;
        endcase
    end

    logic timeout;
    logic start;
    logic capture;
    logic err_set;
    logic stall_c;
    logic misalign_c;

    assign timeout = (wait_cnt_reg == 8'hFF);

    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        capture    = 1'b0;
        err_set    = 1'b0;
        stall_c    = 1'b0;
        misalign_c = 1'b0;
        case (state_reg)
            IDLE: begin
                if (op_present) begin
                    if (misaligned) begin
                        // Let the instruction flow on; the trap logic
                        // downstream acts on the pulse.
                        misalign_c = 1'b1;
                    end else begin
                        stall_c    = 1'b1;
                        start      = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                stall_c = 1'b1;
                if (bus.dmem_gnt) begin
                    state_next = we_reg ? DONE : WAIT_R;
                end else if (timeout) begin
                    err_set    = 1'b1;
                    state_next = DONE;
                end
            end
            WAIT_R: begin
                stall_c = 1'b1;
                if (bus.dmem_rvalid) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end else if (timeout) begin
                    err_set    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                // Stall drops here so the op leaves MEM at this edge; the
                // IDLE that follows only sees whatever moved in behind it.
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            req_reg       <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= 32'h0;
            wdata_reg     <= 32'h0;
            be_reg        <= 4'h0;
            funct3_reg    <= 3'b000;
            offset_reg    <= 2'b00;
            wait_cnt_reg  <= 8'h00;
            read_data_reg <= 32'h0;
            bus_err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            req_reg   <= (state_next == REQ);

            if (start) begin
                we_reg     <= MemWriteM;
                addr_reg   <= {ALUResultM[31:2], 2'b00};
                wdata_reg  <= wdata_fmt;
                be_reg     <= be_fmt;
                funct3_reg <= Funct3M;
                offset_reg <= ALUResultM[1:0];
            end

            // Counter restarts on every entry into a waiting state.
            if ((state_next == REQ && state_reg != REQ) ||
                (state_next == WAIT_R && state_reg != WAIT_R)) begin
                wait_cnt_reg <= 8'h00;
            end else if (state_reg == REQ || state_reg == WAIT_R) begin
                wait_cnt_reg <= wait_cnt_reg + 8'd1;
            end

            if (capture) begin
                read_data_reg <= load_fmt;
            end else if (err_set) begin
                read_data_reg <= 32'h0;
            end

            if (err_set) begin
                bus_err_reg <= 1'b1;
            end
        end
    end

    assign bus.dmem_req   = req_reg;
    assign bus.dmem_we    = we_reg;
    assign bus.dmem_addr  = addr_reg;
    assign bus.dmem_wdata = wdata_reg;
    assign bus.dmem_be    = be_reg;

    // Combinational outputs are forced low while reset is held.
    assign StallMem  = stall_c & ~reset;
    assign MisalignM = misalign_c & ~reset;
    assign ReadDataM = read_data_reg;
    assign BusErr    = bus_err_reg;

endmodule
